// File: rtl/slice_subtractor_seq.sv
// slice_subtractor_seq: a - b - b_in, SLICE bits per clock with a registered borrow; SUB_SIGNED_FLAGS_EN adds ovf/neg
module slice_subtractor_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
`ifdef SUB_SIGNED_FLAGS_EN
  output logic             ovf,
  output logic             neg,
`endif
  output logic             zero
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic [SLICE-1:0] d_k;
  logic borrow, carry, last, acc;
  int lo;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (in_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
              (out_ready ? IDLE : DONE);
    last = idx == LAST;
    lo = int'(idx) * SLICE;
    {carry, d_k} = {1'b0, a_r[lo +: SLICE]} + {1'b0, ~b_r[lo +: SLICE]} + {{SLICE{1'b0}}, ~borrow};
    acc = idx == '0 ? 1'b1 : zero;
  end
  // borrow-out of a slice is the inverted carry of a + ~b + ~borrow
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      borrow <= 1'b0;
      idx <= '0;
      diff <= '0;
      b_out <= 1'b0;
      zero <= 1'b0;
`ifdef SUB_SIGNED_FLAGS_EN
      ovf <= 1'b0;
      neg <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      a_r <= a;
      b_r <= b;
      borrow <= b_in;
      idx <= '0;
    end else if (state == RUN) begin
      diff[lo +: SLICE] <= d_k;
      borrow <= ~carry;
      zero <= acc & ~|d_k;
      idx <= idx + 1'b1;
      if (last) begin
        b_out <= ~carry;
`ifdef SUB_SIGNED_FLAGS_EN
        ovf <= (a_r[WIDTH-1] != b_r[WIDTH-1]) & (d_k[SLICE-1] != a_r[WIDTH-1]);
        neg <= d_k[SLICE-1];
`endif
      end
    end
  end
endmodule

// File: tb/tb_slice_subtractor_seq.sv
// tb_slice_subtractor_seq: directed checks of the sliced subtractor, handshakes and reset abort
module tb_slice_subtractor_seq;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, b_in = 0, out_valid, out_ready = 0;
  logic [31:0] a = 0, b = 0, diff;
  logic b_out, zero;
  logic ovf, neg;
  int cmp = 0, errs = 0, cyc;
  slice_subtractor_seq #(.WIDTH(32), .SLICE(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .b_out(b_out),
`ifdef SUB_SIGNED_FLAGS_EN
    .ovf(ovf), .neg(neg),
`endif
    .zero(zero)
  );
`ifndef SUB_SIGNED_FLAGS_EN
  assign ovf = 1'b0;
  assign neg = 1'b0;
`endif
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin);
    a = ta; b = tb_; b_in = tbin; in_valid = 1;
    chk("in_ready_before_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_done(input string tag);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 2);
  endtask

  task automatic results(input string tag, input logic [31:0] ed, input logic ebo, input logic ez,
                         input logic eovf, input logic eneg);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_b_out"}, b_out, ebo);
    chk({tag, "_zero"}, zero, ez);
`ifdef SUB_SIGNED_FLAGS_EN
    chk({tag, "_ovf"}, ovf, eovf);
    chk({tag, "_neg"}, neg, eneg);
`endif
  endtask

  task automatic transfer(input string tag, input logic [31:0] ed);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({tag, "_ov_drop"}, out_valid, 0);
    chk({tag, "_in_ready_after"}, in_ready, 1);
    chk({tag, "_diff_hold"}, diff, ed);
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_, input logic tbin,
                        input logic [31:0] ed, input logic ebo, input logic ez, input logic eovf, input logic eneg);
    start(ta, tb_, tbin);
    chk({tag, "_ov_early"}, out_valid, 0);
    wait_done(tag);
    results(tag, ed, ebo, ez, eovf, eneg);
    transfer(tag, ed);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_b_out", b_out, 0);
    chk("rst_zero", zero, 0);
`ifdef SUB_SIGNED_FLAGS_EN
    chk("rst_ovf", ovf, 0);
    chk("rst_neg", neg, 0);
`endif
    run_op("t1", 32'h0000_0005, 32'h0000_0003, 0, 32'h0000_0002, 0, 0, 0, 0);
    run_op("t2", 32'h0001_0000, 32'h0000_0001, 0, 32'h0000_FFFF, 0, 0, 0, 0);
    run_op("t3a", 32'h0000_0000, 32'h0000_0001, 0, 32'hFFFF_FFFF, 1, 0, 0, 1);
    run_op("t3b", 32'h8000_0000, 32'h0000_0001, 0, 32'h7FFF_FFFF, 0, 0, 1, 0);
    run_op("t4a", 32'h1234_5678, 32'h1234_5678, 0, 32'h0000_0000, 0, 1, 0, 0);
    run_op("t4b", 32'h1234_5678, 32'h1234_5678, 1, 32'hFFFF_FFFF, 1, 0, 0, 1);
    run_op("t4c", 32'h0000_0000, 32'h0000_0000, 1, 32'hFFFF_FFFF, 1, 0, 0, 1);
    // stall in DONE while new operands are offered
    start(32'h0000_0100, 32'h0000_0001, 0);
    wait_done("t5");
    a = 32'h0000_0007; b = 32'h0000_0007; b_in = 0; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t5_hold_ov", out_valid, 1);
      chk("t5_hold_ir", in_ready, 0);
      chk("t5_hold_diff", diff, 32'h0000_00FF);
      chk("t5_hold_zero", zero, 0);
    end
    in_valid = 0;
    transfer("t5", 32'h0000_00FF);
    repeat (3) @(posedge clk);
    #1 chk("t5_no_capture", out_valid, 0);
    chk("t5_diff_kept", diff, 32'h0000_00FF);
    // reset during the first RUN cycle
    start(32'h0000_0009, 32'h0000_0001, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("t6_ov", out_valid, 0);
    chk("t6_ir", in_ready, 1);
    chk("t6_diff", diff, 0);
    chk("t6_b_out", b_out, 0);
    chk("t6_zero", zero, 0);
    repeat (3) @(posedge clk);
    #1 chk("t6_no_result", out_valid, 0);
    run_op("t6b", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 32'h0000_0000, 0, 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
